// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the hard-wired control sequencer.
// States, opcode map, ALU codes, decode and control bundles.
package control_sequencer_pkg;

  localparam int OP_W = 5;
  localparam int IR_W = 32;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_T0    = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_T4    = 3'd5,
    S_T5    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b10001;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b10010;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b10011;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [OP_W-1:0] ALU_SUB = 5'b00100;
  localparam logic [OP_W-1:0] ALU_AND = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OR  = 5'b00110;

  typedef struct packed {
    logic            is_rtype;
    logic            is_imm;
    logic            is_nop;
    logic            is_halt;
    logic            is_illegal;
    logic [OP_W-1:0] alu_code;
  } dec_t;

  typedef struct packed {
    logic            pc_out;
    logic            mdr_out;
    logic            zlo_out;
    logic            c_out;
    logic            r_out;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            mar_in;
    logic            mdr_in;
    logic            ir_in;
    logic            y_in;
    logic            zlo_in;
    logic            r_in;
    logic            inc_pc;
    logic            mdr_read;
    logic            run;
    logic [OP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR and memory-ready in,
// bus selects, load enables, ALU op and status out.
interface control_sequencer_if #(
  parameter int OPW = 5,
  parameter int IRW = 32
);

  logic [IRW-1:0] ir;
  logic           mem_rdy;

  logic           PCout;
  logic           MDRout;
  logic           ZLOout;
  logic           Cout;
  logic           Rout;
  logic           Gra;
  logic           Grb;
  logic           Grc;
  logic           MARins;
  logic           MDRins;
  logic           IRins;
  logic           Yins;
  logic           ZLOins;
  logic           Rin;
  logic           incPC;
  logic           MDRRead;
  logic [OPW-1:0] alu_op;
  logic           run;
  logic           illegal;

  modport master (
    input  ir, mem_rdy,
    output PCout, MDRout, ZLOout, Cout, Rout,
    output Gra, Grb, Grc,
    output MARins, MDRins, IRins, Yins, ZLOins, Rin,
    output incPC, MDRRead, alu_op, run, illegal
  );

  modport slave (
    output ir, mem_rdy,
    input  PCout, MDRout, ZLOout, Cout, Rout,
    input  Gra, Grb, Grc,
    input  MARins, MDRins, IRins, Yins, ZLOins, Rin,
    input  incPC, MDRRead, alu_op, run, illegal
  );

endinterface

// File: rtl/control_sequencer_op_decode.sv
// Combinational opcode classifier: op in, class flags and
// ALU function code out (immediates map to their R-type op).
module control_sequencer_op_decode
  import control_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op == OP_ADD): begin
        dec.is_rtype = 1'b1;
        dec.alu_code = ALU_ADD;
      end
      (op == OP_SUB): begin
        dec.is_rtype = 1'b1;
        dec.alu_code = ALU_SUB;
      end
      (op == OP_AND): begin
        dec.is_rtype = 1'b1;
        dec.alu_code = ALU_AND;
      end
      (op == OP_OR): begin
        dec.is_rtype = 1'b1;
        dec.alu_code = ALU_OR;
      end
      (op == OP_ADDI): begin
        dec.is_imm   = 1'b1;
        dec.alu_code = ALU_ADD;
      end
      (op == OP_ANDI): begin
        dec.is_imm   = 1'b1;
        dec.alu_code = ALU_AND;
      end
      (op == OP_ORI): begin
        dec.is_imm   = 1'b1;
        dec.alu_code = ALU_OR;
      end
      (op == OP_NOP):  dec.is_nop  = 1'b1;
      (op == OP_HALT): dec.is_halt = 1'b1;
      default:         dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit stepping the shared-bus datapath through
// fetch (T0-T2) and execute (T3-T5); clk/clr plus datapath bundle.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW = OP_W,
  parameter int IRW = IR_W
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  state_t         state_q;
  state_t         state_d;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_ir;
  logic           ill_q;
  dec_t           dec_ir;
  dec_t           dec_op;
  ctrl_t          ctrl;

  assign op_ir = bus.ir[IRW-1 -: OPW];

  // IR is already registered by T3, so it steers the T3 branch;
  // the latched copy drives T4/T5 once IR may move on.
  control_sequencer_op_decode u_dec_ir (
    .op  (op_ir),
    .dec (dec_ir)
  );

  control_sequencer_op_decode u_dec_op (
    .op  (op_q),
    .dec (dec_op)
  );

  logic unused_sigs;
  assign unused_sigs = ^{bus.ir[IRW-OPW-1:0],
                         dec_ir.alu_code,
                         dec_op.is_nop,
                         dec_op.is_halt,
                         dec_op.is_illegal};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RESET;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3) begin
        op_q <= op_ir;
        if (dec_ir.is_illegal) ill_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = bus.mem_rdy ? S_T2 : S_T1;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (dec_ir.is_rtype || dec_ir.is_imm)
          state_d = S_T4;
        else if (dec_ir.is_halt)
          state_d = S_HALT;
        else
          state_d = S_T0;
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_RESET: ctrl = '0;
      S_T0: begin
        ctrl.run    = 1'b1;
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
      end
      S_T1: begin
        ctrl.run      = 1'b1;
        ctrl.mdr_read = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      S_T2: begin
        ctrl.run     = 1'b1;
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      S_T3: begin
        ctrl.run = 1'b1;
        if (dec_ir.is_rtype || dec_ir.is_imm) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
        end
      end
      S_T4: begin
        ctrl.run    = 1'b1;
        ctrl.zlo_in = 1'b1;
        ctrl.alu_op = dec_op.alu_code;
        if (dec_op.is_imm) begin
          ctrl.c_out = 1'b1;
        end else if (dec_op.is_rtype) begin
          ctrl.grc   = 1'b1;
          ctrl.r_out = 1'b1;
        end
      end
      S_T5: begin
        ctrl.run     = 1'b1;
        ctrl.zlo_out = 1'b1;
        ctrl.gra     = 1'b1;
        ctrl.r_in    = 1'b1;
      end
      S_HALT: ctrl = '0;
    endcase
  end

  assign bus.PCout   = ctrl.pc_out;
  assign bus.MDRout  = ctrl.mdr_out;
  assign bus.ZLOout  = ctrl.zlo_out;
  assign bus.Cout    = ctrl.c_out;
  assign bus.Rout    = ctrl.r_out;
  assign bus.Gra     = ctrl.gra;
  assign bus.Grb     = ctrl.grb;
  assign bus.Grc     = ctrl.grc;
  assign bus.MARins  = ctrl.mar_in;
  assign bus.MDRins  = ctrl.mdr_in;
  assign bus.IRins   = ctrl.ir_in;
  assign bus.Yins    = ctrl.y_in;
  assign bus.ZLOins  = ctrl.zlo_in;
  assign bus.Rin     = ctrl.r_in;
  assign bus.incPC   = ctrl.inc_pc;
  assign bus.MDRRead = ctrl.mdr_read;
  assign bus.alu_op  = ctrl.alu_op;
  assign bus.run     = ctrl.run;
  assign bus.illegal = ill_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute strobes,
// wait states, illegal flag, halt and async clear.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0      = 0;

  control_sequencer_if #(.OPW(5), .IRW(32)) bus ();

  control_sequencer #(.OPW(5), .IRW(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [22:0] PCOUT   = 23'(1) << 22;
  localparam logic [22:0] MDROUT  = 23'(1) << 21;
  localparam logic [22:0] ZLOOUT  = 23'(1) << 20;
  localparam logic [22:0] COUT    = 23'(1) << 19;
  localparam logic [22:0] ROUT    = 23'(1) << 18;
  localparam logic [22:0] GRA     = 23'(1) << 17;
  localparam logic [22:0] GRB     = 23'(1) << 16;
  localparam logic [22:0] GRC     = 23'(1) << 15;
  localparam logic [22:0] MARINS  = 23'(1) << 14;
  localparam logic [22:0] MDRINS  = 23'(1) << 13;
  localparam logic [22:0] IRINS   = 23'(1) << 12;
  localparam logic [22:0] YINS    = 23'(1) << 11;
  localparam logic [22:0] ZLOINS  = 23'(1) << 10;
  localparam logic [22:0] RIN     = 23'(1) << 9;
  localparam logic [22:0] INCPC   = 23'(1) << 8;
  localparam logic [22:0] MDRREAD = 23'(1) << 7;
  localparam logic [22:0] RUN     = 23'(1) << 6;
  localparam logic [22:0] ILL     = 23'(1);

  localparam logic [22:0] E_T0  = PCOUT | MARINS | INCPC | RUN;
  localparam logic [22:0] E_T1  = MDRREAD | MDRINS | RUN;
  localparam logic [22:0] E_T2  = MDROUT | IRINS | RUN;
  localparam logic [22:0] E_T3A = GRB | ROUT | YINS | RUN;
  localparam logic [22:0] E_T3N = RUN;
  localparam logic [22:0] E_T5  = ZLOOUT | GRA | RIN | RUN;

  function automatic logic [22:0] t4i(input logic [4:0] c);
    return COUT | ZLOINS | RUN | (23'(c) << 1);
  endfunction

  function automatic logic [22:0] t4r(input logic [4:0] c);
    return GRC | ROUT | ZLOINS | RUN | (23'(c) << 1);
  endfunction

  function automatic logic [22:0] vec();
    return {bus.PCout, bus.MDRout, bus.ZLOout, bus.Cout,
            bus.Rout, bus.Gra, bus.Grb, bus.Grc,
            bus.MARins, bus.MDRins, bus.IRins, bus.Yins,
            bus.ZLOins, bus.Rin, bus.incPC, bus.MDRRead,
            bus.run, bus.alu_op, bus.illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [22:0] exp);
    logic [22:0] obs;
    obs = vec();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus.ir      = 32'h0;
    bus.mem_rdy = 1'b1;
    step();
    step();
    chk("reset", 23'h0);

    // addi, no wait states
    bus.ir = 32'h8800_0136;
    clr    = 1'b0;
    step(); chk("addi_t0", E_T0);
    c0 = cyc;
    step(); chk("addi_t1", E_T1);
    step(); chk("addi_t2", E_T2);
    step(); chk("addi_t3", E_T3A);
    step(); chk("addi_t4", t4i(5'b00011));
    step(); chk("addi_t5", E_T5);
    step(); chk("addi_next_t0", E_T0);
    chk_int("addi_cycles", cyc - c0, 6);

    // clear asserted in the middle of T4
    step(); step(); step();
    step(); chk("addi2_t4", t4i(5'b00011));
    clr = 1'b1;
    #1;
    chk("async_clr", 23'h0);
    clr = 1'b0;
    step(); chk("clr_t0", E_T0);

    // andi with three wait cycles in T1
    c0 = cyc;
    bus.ir      = 32'h9000_0000;
    bus.mem_rdy = 1'b0;
    step(); chk("andi_t1a", E_T1);
    step(); chk("andi_t1b", E_T1);
    step(); chk("andi_t1c", E_T1);
    step(); chk("andi_t1d", E_T1);
    bus.mem_rdy = 1'b1;
    step(); chk("andi_t2", E_T2);
    step(); chk("andi_t3", E_T3A);
    step(); chk("andi_t4", t4i(5'b00101));
    step(); chk("andi_t5", E_T5);
    step(); chk("andi_next_t0", E_T0);
    chk_int("andi_cycles", cyc - c0, 9);

    // add (R-type)
    bus.ir = 32'h1800_0000;
    step(); chk("add_t1", E_T1);
    step(); chk("add_t2", E_T2);
    step(); chk("add_t3", E_T3A);
    step(); chk("add_t4", t4r(5'b00011));
    step(); chk("add_t5", E_T5);
    step(); chk("add_next_t0", E_T0);

    // undefined opcode 11111
    bus.ir = 32'hF800_0000;
    step(); chk("ill_t1", E_T1);
    step(); chk("ill_t2", E_T2);
    step(); chk("ill_t3", E_T3N);
    step(); chk("ill_t0", E_T0 | ILL);

    // nop afterwards, flag stays set
    c0 = cyc;
    bus.ir = 32'hD000_0000;
    step(); chk("nop_t1", E_T1 | ILL);
    step(); chk("nop_t2", E_T2 | ILL);
    step(); chk("nop_t3", E_T3N | ILL);
    step(); chk("nop_t0", E_T0 | ILL);
    chk_int("nop_cycles", cyc - c0, 4);

    // halt
    bus.ir = 32'hD800_0000;
    step(); chk("halt_t1", E_T1 | ILL);
    step(); chk("halt_t2", E_T2 | ILL);
    step(); chk("halt_t3", E_T3N | ILL);
    for (int i = 0; i < 20; i++) begin
      bus.mem_rdy = i[0];
      step();
      chk($sformatf("halt_hold%0d", i), ILL);
    end
    bus.mem_rdy = 1'b1;
    clr = 1'b1;
    #1;
    chk("halt_clr", 23'h0);
    step();
    clr = 1'b0;
    step(); chk("restart_t0", E_T0);
    step(); chk("restart_t1", E_T1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
